// File: rtl/moxie_wb_arbiter.sv
// Two-master Wishbone arbiter for the moxie core: instruction and data ports
// share one slave bus with round-robin tie-breaking and an ack watchdog.
module moxie_wb_arbiter #(
   parameter int unsigned TIMEOUT_W = 8,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic [31:0] wbm_I_adr_i,
   input  logic [31:0] wbm_I_dat_i,
   input  logic [3:0]  wbm_I_sel_i,
   input  logic        wbm_I_we_i,
   input  logic        wbm_I_cyc_i,
   input  logic        wbm_I_stb_i,
   output logic [31:0] wbm_I_dat_o,
   output logic        wbm_I_ack_o,
   output logic        wbm_I_err_o,

   input  logic [31:0] wbm_D_adr_i,
   input  logic [31:0] wbm_D_dat_i,
   input  logic [3:0]  wbm_D_sel_i,
   input  logic        wbm_D_we_i,
   input  logic        wbm_D_cyc_i,
   input  logic        wbm_D_stb_i,
   output logic [31:0] wbm_D_dat_o,
   output logic        wbm_D_ack_o,
   output logic        wbm_D_err_o,

   output logic [31:0] wbs_adr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   output logic        wbs_we_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   input  logic [31:0] wbs_dat_i,
   input  logic        wbs_ack_i
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   localparam logic [TIMEOUT_W-1:0] WDT_LAST = TIMEOUT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
      logic          we;
      logic          cyc;
      logic          stb;
   } wb_req_t;

   state_t               state;
   state_t               state_nxt;
   logic                 last_grant;
   logic                 last_grant_nxt;
   logic [TIMEOUT_W-1:0] wdt;
   logic [TIMEOUT_W-1:0] wdt_nxt;
   logic                 stb_kill;
   logic                 stb_kill_nxt;

   wb_req_t req_i;
   wb_req_t req_d;
   wb_req_t req_sel;
   logic    gnt_i;
   logic    gnt_d;
   logic    timeout_c;

   assign req_i = '{adr: wbm_I_adr_i, dat: wbm_I_dat_i, sel: wbm_I_sel_i,
                    we: wbm_I_we_i, cyc: wbm_I_cyc_i, stb: wbm_I_stb_i};
   assign req_d = '{adr: wbm_D_adr_i, dat: wbm_D_dat_i, sel: wbm_D_sel_i,
                    we: wbm_D_we_i, cyc: wbm_D_cyc_i, stb: wbm_D_stb_i};

   assign gnt_i = (state == GRANT_I);
   assign gnt_d = (state == GRANT_D);

   // Owner's request onto the slave bus; all zero while idle
   always_comb begin
      req_sel = '0;
      case (state)
         GRANT_I: req_sel = req_i;
         GRANT_D: req_sel = req_d;
         default: req_sel = '0;
      endcase
   end

   assign wbs_adr_o = req_sel.adr;
   assign wbs_dat_o = req_sel.dat;
   assign wbs_sel_o = req_sel.sel;
   assign wbs_we_o  = req_sel.we;
   assign wbs_cyc_o = req_sel.cyc;
   assign wbs_stb_o = req_sel.stb & ~stb_kill;

   // Ack takes priority over a coinciding timeout
   assign timeout_c = wbs_stb_o & ~wbs_ack_i & (wdt == WDT_LAST);

   assign wbm_I_dat_o = gnt_i ? wbs_dat_i : '0;
   assign wbm_D_dat_o = gnt_d ? wbs_dat_i : '0;
   assign wbm_I_ack_o = gnt_i & wbs_ack_i & wbs_stb_o;
   assign wbm_D_ack_o = gnt_d & wbs_ack_i & wbs_stb_o;
   assign wbm_I_err_o = gnt_i & timeout_c;
   assign wbm_D_err_o = gnt_d & timeout_c;

   // Arbitration: grant held for the owner's whole cyc, ties alternate
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (wbm_D_cyc_i && (!wbm_I_cyc_i || (last_grant == LG_I))) begin
               state_nxt      = GRANT_D;
               last_grant_nxt = LG_D;
            end else if (wbm_I_cyc_i) begin
               state_nxt      = GRANT_I;
               last_grant_nxt = LG_I;
            end
         end
         GRANT_I: begin
            if (!wbm_I_cyc_i) state_nxt = IDLE;
         end
         GRANT_D: begin
            if (!wbm_D_cyc_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog and strobe kill; kill holds until the owner retracts its strobe
   always_comb begin
      wdt_nxt      = wdt + TIMEOUT_W'(1);
      stb_kill_nxt = stb_kill;
      if (!wbs_stb_o || wbs_ack_i || timeout_c) wdt_nxt = '0;
      if (timeout_c) begin
         stb_kill_nxt = 1'b1;
      end else if (!(req_sel.cyc && req_sel.stb)) begin
         stb_kill_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         last_grant <= LG_I;
         wdt        <= '0;
         stb_kill   <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wdt        <= wdt_nxt;
         stb_kill   <= stb_kill_nxt;
      end
   end

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Directed bench for moxie_wb_arbiter: a scoreboard queue of expected master
// responses checked by a monitor, plus cycle-exact grant/timing checks.
module tb_moxie_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_adr, i_dat, i_rdat;
   logic [3:0]  i_sel;
   logic        i_we, i_cyc, i_stb, i_ack, i_err;
   logic [31:0] d_adr, d_dat, d_rdat;
   logic [3:0]  d_sel;
   logic        d_we, d_cyc, d_stb, d_ack, d_err;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb, s_ack;

   typedef struct {
      bit          port;
      bit          is_err;
      logic [31:0] dat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errors  = 0;

   int          slv_lat   = 0;
   bit          slv_force = 0;
   logic [31:0] slv_data  = 32'h0;
   int          slv_cnt   = 0;

   moxie_wb_arbiter #(.TIMEOUT_W(8), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .wbm_I_adr_i(i_adr), .wbm_I_dat_i(i_dat), .wbm_I_sel_i(i_sel),
      .wbm_I_we_i(i_we), .wbm_I_cyc_i(i_cyc), .wbm_I_stb_i(i_stb),
      .wbm_I_dat_o(i_rdat), .wbm_I_ack_o(i_ack), .wbm_I_err_o(i_err),
      .wbm_D_adr_i(d_adr), .wbm_D_dat_i(d_dat), .wbm_D_sel_i(d_sel),
      .wbm_D_we_i(d_we), .wbm_D_cyc_i(d_cyc), .wbm_D_stb_i(d_stb),
      .wbm_D_dat_o(d_rdat), .wbm_D_ack_o(d_ack), .wbm_D_err_o(d_err),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel),
      .wbs_we_o(s_we), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
      .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench timeout");
   end

   // Slave model: acks after slv_lat cycles of continuous strobe
   always @(posedge clk) begin
      #2;
      if (!s_stb) begin
         slv_cnt = 0;
         s_ack   = slv_force;
      end else if (slv_cnt == slv_lat) begin
         slv_cnt = 0;
         s_ack   = 1'b1;
      end else begin
         slv_cnt = slv_cnt + 1;
         s_ack   = slv_force;
      end
      s_rdat = slv_data;
   end

   // Monitor: every master ack/err must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && (i_ack || i_err || d_ack || d_err)) begin
         vectors = vectors + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_unexpected: got ack I/D=%b%b err I/D=%b%b, required no response",
                     i_ack, d_ack, i_err, d_err);
         end else begin
            mon_e = exp_q.pop_front();
            if (($countones({i_ack, i_err, d_ack, d_err}) != 1) ||
                ((d_ack || d_err) != mon_e.port) ||
                ((i_err || d_err) != mon_e.is_err) ||
                (!mon_e.is_err && ((mon_e.port ? d_rdat : i_rdat) != mon_e.dat)) ||
                ((mon_e.port ? i_rdat : d_rdat) != 32'h0)) begin
               errors = errors + 1;
               $display("FAIL sb_resp: got ackI=%b errI=%b ackD=%b errD=%b datI=%h datD=%h, required port=%0d err=%0d dat=%h",
                        i_ack, i_err, d_ack, d_err, i_rdat, d_rdat, mon_e.port, mon_e.is_err, mon_e.dat);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic push(input bit port, input bit is_err, input logic [31:0] dat);
      exp_q.push_back('{port: port, is_err: is_err, dat: dat});
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic drv_i(input bit cyc, input bit stb, input logic [31:0] adr, input bit we);
      i_cyc = cyc; i_stb = stb; i_adr = adr; i_we = we;
      i_dat = adr ^ 32'h1111_1111; i_sel = 4'hF;
   endtask

   task automatic drv_d(input bit cyc, input bit stb, input logic [31:0] adr, input bit we);
      d_cyc = cyc; d_stb = stb; d_adr = adr; d_we = we;
      d_dat = adr ^ 32'h2222_2222; d_sel = 4'hF;
   endtask

   task automatic do_reset();
      next();
      rst_n = 1'b0;
      drv_i(0, 0, 32'h0, 0);
      drv_d(0, 0, 32'h0, 0);
      slv_lat = 0;
      slv_force = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      s_ack = 1'b0;
      s_rdat = 32'hFFFF_FFFF;
      drv_i(0, 0, 32'h0, 0);
      drv_d(0, 0, 32'h0, 0);
      #3;
      chk("rst_slave_ctl", 32'({s_cyc, s_stb, s_we, s_sel}), 32'h0);
      chk("rst_slave_adr", s_adr, 32'h0);
      chk("rst_slave_dat", s_wdat, 32'h0);
      chk("rst_master_ctl", 32'({i_ack, i_err, d_ack, d_err}), 32'h0);
      chk("rst_master_dat", i_rdat | d_rdat, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single read on the instruction port, slave acks two cycles in
      slv_lat = 2; slv_data = 32'hDEAD_BEEF;
      push(0, 0, 32'hDEAD_BEEF);
      drv_i(1, 1, 32'h1000, 0);
      at_neg(); chk("t1_idle_latency", 32'(s_cyc), 32'h0);
      at_neg(); chk("t1_adr", s_adr, 32'h1000);
      chk("t1_d_quiet", 32'({d_ack, d_err}) | d_rdat, 32'h0);
      at_neg(); chk("t1_no_early_ack", 32'(i_ack), 32'h0);
      at_neg(); chk("t1_ack", 32'(i_ack), 32'h1);
      chk("t1_rdat", i_rdat, 32'hDEAD_BEEF);
      next(); drv_i(0, 0, 32'h0, 0);
      next();

      // Ties: first to D after reset, one bubble, then alternation
      do_reset();
      slv_lat = 0; slv_data = 32'hC0FF_EE01;
      push(1, 0, 32'hC0FF_EE01);
      push(0, 0, 32'hC0FF_EE01);
      drv_i(1, 1, 32'h100, 0);
      drv_d(1, 1, 32'h200, 1);
      at_neg();
      at_neg(); chk("t2_tie_to_d", s_adr, 32'h200);
      next(); drv_d(0, 0, 32'h0, 0);
      at_neg(); chk("t2_release", 32'(s_cyc), 32'h0);
      at_neg(); chk("t2_bubble", 32'(s_cyc), 32'h0);
      at_neg(); chk("t2_i_after_bubble", s_adr, 32'h100);
      next(); drv_i(0, 0, 32'h0, 0);
      next();
      push(1, 0, 32'hC0FF_EE01);
      drv_i(1, 1, 32'h100, 0);
      drv_d(1, 1, 32'h200, 1);
      at_neg();
      at_neg(); chk("t2_tie_after_i_to_d", s_adr, 32'h200);
      next(); drv_i(0, 0, 32'h0, 0); drv_d(0, 0, 32'h0, 0);
      next(); next();
      push(0, 0, 32'hC0FF_EE01);
      drv_i(1, 1, 32'h100, 0);
      drv_d(1, 1, 32'h200, 1);
      at_neg();
      at_neg(); chk("t2_tie_after_d_to_i", s_adr, 32'h100);
      next(); drv_i(0, 0, 32'h0, 0); drv_d(0, 0, 32'h0, 0);
      next(); next();

      // Burst of four D writes while I waits
      slv_data = 32'h0BAD_F00D;
      for (int k = 0; k < 4; k++) push(1, 0, 32'h0BAD_F00D);
      drv_d(1, 1, 32'h2000, 1);
      at_neg();
      for (int k = 0; k < 4; k++) begin
         at_neg();
         chk("t3_burst_adr", s_adr, 32'h2000 + 32'(4 * k));
         chk("t3_burst_ctl", 32'({s_we, s_sel, s_stb}), 32'h3F);
         chk("t3_burst_wdat", s_wdat, (32'h2000 + 32'(4 * k)) ^ 32'h2222_2222);
         next();
         if (k == 0) drv_i(1, 1, 32'h3000, 0);
         if (k < 3) drv_d(1, 1, 32'h2000 + 32'(4 * (k + 1)), 1);
         else drv_d(0, 0, 32'h0, 0);
      end
      push(0, 0, 32'h0BAD_F00D);
      at_neg(); chk("t3_no_i_m", 32'(s_cyc), 32'h0);
      at_neg(); chk("t3_no_i_m1", 32'(s_cyc), 32'h0);
      at_neg(); chk("t3_i_at_m2", s_adr, 32'h3000);
      next(); drv_i(0, 0, 32'h0, 0);
      next(); next();

      // Timeout: err at S+7, strobe killed, late ack dropped
      slv_lat = 1000;
      push(0, 1, 32'h0);
      drv_i(1, 1, 32'h4000, 0);
      at_neg();
      for (int k = 0; k < 7; k++) begin
         at_neg(); chk("t4_no_err_before", 32'({i_err, i_ack}), 32'h0);
      end
      at_neg(); chk("t4_err_pulse", 32'({i_err, i_ack}), 32'h2);
      at_neg(); chk("t4_stb_killed", 32'({s_stb, i_err}), 32'h0);
      next(); slv_force = 1;
      at_neg(); chk("t4_late_ack_blocked", 32'({i_ack, i_err, s_stb}), 32'h0);
      next(); slv_force = 0; drv_i(0, 0, 32'h0, 0);
      next(); next();

      // Ack exactly at the timeout cycle wins; watchdog restarts from zero
      slv_lat = 7;
      push(0, 0, 32'h0BAD_F00D);
      drv_i(1, 1, 32'h5000, 0);
      at_neg();
      for (int k = 0; k < 7; k++) begin
         at_neg(); chk("t5_quiet", 32'({i_err, i_ack}), 32'h0);
      end
      at_neg(); chk("t5_ack_wins", 32'({i_err, i_ack}), 32'h1);
      slv_lat = 1000;
      push(0, 1, 32'h0);
      next(); drv_i(1, 1, 32'h5004, 0);
      for (int k = 0; k < 7; k++) begin
         if (k > 0) next();
         at_neg(); chk("t5_wdt_restart_quiet", 32'(i_err), 32'h0);
      end
      at_neg(); chk("t5_wdt_restart_err", 32'(i_err), 32'h1);
      next(); drv_i(0, 0, 32'h0, 0);
      next(); next();

      // Reset mid-transfer with D granted; afterwards the tie goes to D again
      drv_d(1, 1, 32'h6000, 1);
      at_neg();
      at_neg(); chk("t6_d_granted", s_adr, 32'h6000);
      next(); drv_i(1, 1, 32'h7000, 0);
      next(); rst_n = 1'b0;
      #1;
      chk("t6_rst_slave_ctl", 32'({s_cyc, s_stb, s_we, s_sel}), 32'h0);
      chk("t6_rst_slave_bus", s_adr | s_wdat, 32'h0);
      chk("t6_rst_master", 32'({d_ack, d_err, i_ack, i_err}) | d_rdat, 32'h0);
      next();
      next(); rst_n = 1'b1; slv_lat = 0;
      push(1, 0, 32'h0BAD_F00D);
      at_neg();
      at_neg(); chk("t6_tie_after_reset", s_adr, 32'h6000);
      next(); drv_i(0, 0, 32'h0, 0); drv_d(0, 0, 32'h0, 0);
      repeat (3) next();

      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
